// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score engine.
//   award_e     - stage-1 classification of a sampled ball event
//   calc_gw()   - group-index width, never below one bit
//   def_mask()  - power-on scoring-hole mask for a table entry
//   def_points()- power-on base points for a table entry
package score_pkg;

  typedef enum logic [1:0] {
    AWARD_NONE = 2'd0,   // nothing accepted this cycle
    AWARD_HIT  = 2'd1,   // accepted ball landed in a scoring hole
    AWARD_MISS = 2'd2    // accepted ball missed every scoring hole
  } award_e;

  localparam int DEF_ENTRIES = 8;

  function automatic int calc_gw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] def_mask(input int idx);
    logic [7:0] m;
    case (idx)
      0:       m = 8'hAA;
      1:       m = 8'h92;
      2:       m = 8'h48;
      3:       m = 8'h04;
      4:       m = 8'h55;
      5:       m = 8'h49;
      6:       m = 8'h12;
      7:       m = 8'h20;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic int def_points(input int idx);
    int p;
    case (idx)
      0, 4:    p = 10;
      1, 5:    p = 20;
      2, 6:    p = 50;
      3, 7:    p = 100;
      default: p = 0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/score_engine_if.sv
// score_engine_if: ball-event and table-configuration bus of the score engine.
//   play/ball_valid/ball/group_sel          - ball landing event
//   cfg_we/cfg_idx/cfg_mask/cfg_points      - group-table write port
//   master: driver side (game controller), slave: score engine side
interface score_engine_if #(
  parameter int N_HOLES  = 8,
  parameter int N_GROUPS = 8,
  parameter int SCORE_W  = 15
) ();
  import score_pkg::*;

  localparam int GW = calc_gw(N_GROUPS);

  logic               play;
  logic               ball_valid;
  logic [N_HOLES-1:0] ball;
  logic [GW-1:0]      group_sel;
  logic               cfg_we;
  logic [GW-1:0]      cfg_idx;
  logic [N_HOLES-1:0] cfg_mask;
  logic [SCORE_W-1:0] cfg_points;

  modport master (
    output play, ball_valid, ball, group_sel,
    output cfg_we, cfg_idx, cfg_mask, cfg_points
  );

  modport slave (
    input play, ball_valid, ball, group_sel,
    input cfg_we, cfg_idx, cfg_mask, cfg_points
  );

endinterface

// File: rtl/score_group_table.sv
// score_group_table: N_GROUPS entries of {scoring-hole mask, base points}.
//   clk, rst_n          - clock, synchronous active-low reset (loads defaults)
//   wr_en/wr_idx/...    - write port; indexes >= N_GROUPS are dropped
//   rd_idx              - combinational read select
//   rd_mask/rd_points   - selected entry (zero for an out-of-range index)
// A write becomes visible on the cycle after wr_en, so a read in the same
// cycle as a write returns the old contents.
module score_group_table
  import score_pkg::*;
#(
  parameter int N_HOLES  = 8,
  parameter int N_GROUPS = 8,
  parameter int SCORE_W  = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [calc_gw(N_GROUPS)-1:0]     wr_idx,
  input  logic [N_HOLES-1:0]               wr_mask,
  input  logic [SCORE_W-1:0]               wr_points,
  input  logic [calc_gw(N_GROUPS)-1:0]     rd_idx,
  output logic [N_HOLES-1:0]               rd_mask,
  output logic [SCORE_W-1:0]               rd_points
);

  localparam int GW = calc_gw(N_GROUPS);
  // Entry count held one bit wider than the index so it is representable.
  localparam logic [GW:0] N_ENT = (GW+1)'(N_GROUPS);

  logic [N_HOLES-1:0] mask_all   [N_GROUPS];
  logic [SCORE_W-1:0] points_all [N_GROUPS];
  logic               wr_ok;

  assign wr_ok = wr_en && ({1'b0, wr_idx} < N_ENT);

  for (genvar gi = 0; gi < N_GROUPS; gi++) begin : g_ent
    logic [N_HOLES-1:0] mask_q,   mask_d;
    logic [SCORE_W-1:0] points_q, points_d;

    always_comb begin
      mask_d   = mask_q;
      points_d = points_q;
      if (wr_ok && (wr_idx == GW'(gi))) begin
        mask_d   = wr_mask;
        points_d = wr_points;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mask_q   <= N_HOLES'(def_mask(gi));
        points_q <= SCORE_W'(def_points(gi));
      end else begin
        mask_q   <= mask_d;
        points_q <= points_d;
      end
    end

    assign mask_all[gi]   = mask_q;
    assign points_all[gi] = points_q;
  end

  always_comb begin
    rd_mask   = '0;
    rd_points = '0;
    if ({1'b0, rd_idx} < N_ENT) begin
      rd_mask   = mask_all[rd_idx];
      rd_points = points_all[rd_idx];
    end
  end

endmodule

// File: rtl/score_engine.sv
// score_engine: pinball-style scoring with combo multiplier.
//   clk, rst_n   - clock, synchronous active-low reset
//   clear        - new game: bank high score, zero game state and pipeline
//   bus (slave)  - ball event (play, ball_valid, ball, group_sel) and
//                  group-table write (cfg_we, cfg_idx, cfg_mask, cfg_points)
//   score        - current game score, saturating
//   win          - sticky, set the cycle after score reaches WIN_SCORE
//   hit          - one-cycle pulse when an award is applied
//   combo        - consecutive-hit count, capped at COMBO_MAX
//   high_score   - best score banked by clear
// Stage 1 classifies the ball against the selected table entry; stage 2
// applies the award, so an event reaches score two edges after it is driven.
module score_engine
  import score_pkg::*;
#(
  parameter int N_HOLES   = 8,
  parameter int N_GROUPS  = 8,
  parameter int SCORE_W   = 15,
  parameter int WIN_SCORE = 100,
  parameter int COMBO_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  score_engine_if.slave                      bus,
  output logic [SCORE_W-1:0]                 score,
  output logic                               win,
  output logic                               hit,
  output logic [$clog2(COMBO_MAX+1)-1:0]     combo,
  output logic [SCORE_W-1:0]                 high_score
);

  localparam int CW = $clog2(COMBO_MAX + 1);
  localparam int PW = 2 * SCORE_W;
  localparam logic [CW-1:0]      COMBO_CAP = CW'(COMBO_MAX);
  localparam logic [PW-1:0]      SCORE_SAT = {{SCORE_W{1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]   WIN_THR   = (SCORE_W+1)'(WIN_SCORE);

  logic [N_HOLES-1:0] rd_mask;
  logic [SCORE_W-1:0] rd_points;

  score_group_table #(
    .N_HOLES  (N_HOLES),
    .N_GROUPS (N_GROUPS),
    .SCORE_W  (SCORE_W)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (bus.cfg_we),
    .wr_idx    (bus.cfg_idx),
    .wr_mask   (bus.cfg_mask),
    .wr_points (bus.cfg_points),
    .rd_idx    (bus.group_sel),
    .rd_mask   (rd_mask),
    .rd_points (rd_points)
  );

  // Stage 1 state
  award_e             s1_kind_q, s1_kind_d;
  logic [SCORE_W-1:0] s1_base_q, s1_base_d;

  // Stage 2 / game state
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CW-1:0]      combo_q, combo_d;
  logic               hit_q, hit_d;
  logic               win_q, win_d;
  logic [SCORE_W-1:0] high_q, high_d;

  logic [CW-1:0]      combo_inc;
  logic [PW-1:0]      product;
  logic [PW-1:0]      total;

  // Any overlap of ball with the mask is one event, however many holes hit.
  always_comb begin
    s1_kind_d = AWARD_NONE;
    s1_base_d = rd_points;
    if (bus.play && bus.ball_valid) begin
      s1_kind_d = (|(bus.ball & rd_mask)) ? AWARD_HIT : AWARD_MISS;
    end
    if (clear) begin
      s1_kind_d = AWARD_NONE;
    end
  end

  always_comb begin
    combo_inc = (combo_q >= COMBO_CAP) ? COMBO_CAP : combo_q + CW'(1);
    product   = PW'(s1_base_q) * PW'(combo_inc);
    total     = PW'(score_q) + product;

    score_d = score_q;
    combo_d = combo_q;
    hit_d   = 1'b0;
    high_d  = high_q;
    // win looks at the score already registered, hence one cycle behind it.
    win_d   = win_q | ({1'b0, score_q} >= WIN_THR);

    case (s1_kind_q)
      AWARD_HIT: begin
        combo_d = combo_inc;
        score_d = (total > SCORE_SAT) ? {SCORE_W{1'b1}} : total[SCORE_W-1:0];
        hit_d   = 1'b1;
      end
      AWARD_MISS: begin
        combo_d = '0;
      end
      default: ;
    endcase

    // clear overrides whatever stage 2 would have applied this cycle.
    if (clear) begin
      high_d  = (score_q > high_q) ? score_q : high_q;
      score_d = '0;
      combo_d = '0;
      hit_d   = 1'b0;
      win_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_kind_q <= AWARD_NONE;
      s1_base_q <= '0;
      score_q   <= '0;
      combo_q   <= '0;
      hit_q     <= 1'b0;
      win_q     <= 1'b0;
      high_q    <= '0;
    end else begin
      s1_kind_q <= s1_kind_d;
      s1_base_q <= s1_base_d;
      score_q   <= score_d;
      combo_q   <= combo_d;
      hit_q     <= hit_d;
      win_q     <= win_d;
      high_q    <= high_d;
    end
  end

  assign score      = score_q;
  assign combo      = combo_q;
  assign hit        = hit_q;
  assign win        = win_q;
  assign high_score = high_q;

endmodule
